// File: rtl/io_port_unit.sv
// Memory-mapped I/O responder: one-word input holding register for loads from
// the input port and a circular FIFO feeding the output device from stores.
module io_port_unit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sig,
  input  logic             out_sig,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OUT_DEPTH);

  logic             in_full_q, in_full_d;
  logic [WIDTH-1:0] in_buf_q,  in_buf_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PTR_W:0]   count_q,   count_d;
  logic [WIDTH-1:0] mem_q [OUT_DEPTH];

  logic in_take;
  logic in_consume;
  logic out_full;
  logic out_push;
  logic out_pop;

  // Fullness uses the registered count only, so ext_out_ready never reaches stall.
  always_comb begin
    in_take    = ext_in_valid && ext_in_ready;
    in_consume = in_sig && in_full_q;
    out_full   = (count_q == FULL_CNT);
    out_push   = out_sig && !out_full;
    out_pop    = ext_out_valid && ext_out_ready;
  end

  // Reset gating keeps the handshake and stall quiet while reset is held.
  assign ext_in_ready  = !reset && !in_full_q;
  assign ext_out_valid = (count_q != '0);
  assign ext_out_data  = mem_q[rd_ptr_q];
  assign rd_data       = in_consume ? in_buf_q : '0;
  assign stall         = !reset && ((in_sig && !in_full_q) || (out_sig && out_full));

  always_comb begin
    in_full_d = in_full_q;
    in_buf_d  = in_buf_q;
    if (in_take) begin
      in_full_d = 1'b1;
      in_buf_d  = ext_in_data;
    end else if (in_consume) begin
      in_full_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (out_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (out_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({out_push, out_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_full_q <= 1'b0;
      in_buf_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      in_full_q <= in_full_d;
      in_buf_q  <= in_buf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is cleared too so ext_out_data reads zero during and after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (out_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: directed input-port checks plus a
// scoreboard queue of expected output-device words.
module tb_io_port_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_sig;
  logic         out_sig;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_data;
  logic         stall;
  logic [W-1:0] ext_in_data;
  logic         ext_in_valid;
  logic         ext_in_ready;
  logic [W-1:0] ext_out_data;
  logic         ext_out_valid;
  logic         ext_out_ready;

  int unsigned  n_total = 0;
  int unsigned  n_bad   = 0;
  logic [W-1:0] exp_q[$];

  io_port_unit #(.WIDTH(W), .OUT_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_sig        (in_sig),
    .out_sig       (out_sig),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .stall         (stall),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Any handshake visible mid-cycle completes at the next edge.
  always @(negedge clk) begin
    if (!reset && ext_out_valid && ext_out_ready) begin
      chk_eq("out_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk_eq("out_data", 32'(ext_out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_sig = 1'b1; out_sig = 1'b1; wr_data = '0;
    ext_in_data = '0; ext_in_valid = 1'b1; ext_out_ready = 1'b0;
    #2;
    chk_eq("rst_in_ready",  32'(ext_in_ready),  32'd0);
    chk_eq("rst_out_valid", 32'(ext_out_valid), 32'd0);
    chk_eq("rst_out_data",  32'(ext_out_data),  32'd0);
    chk_eq("rst_rd_data",   32'(rd_data),       32'd0);
    chk_eq("rst_stall",     32'(stall),         32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0; in_sig = 1'b0; out_sig = 1'b0; ext_in_valid = 1'b0;
    sample();
    chk_eq("post_rst_in_ready",  32'(ext_in_ready),  32'd1);
    chk_eq("post_rst_out_valid", 32'(ext_out_valid), 32'd0);
    chk_eq("post_rst_stall",     32'(stall),         32'd0);

    // Basic capture then read
    next_cycle();
    ext_in_data = 16'h1234; ext_in_valid = 1'b1;
    sample();
    chk_eq("t1_ready_cap", 32'(ext_in_ready), 32'd1);
    chk_eq("t1_rd_idle",   32'(rd_data),      32'd0);
    next_cycle();
    ext_in_valid = 1'b0; in_sig = 1'b1;
    sample();
    chk_eq("t1_rd",       32'(rd_data),      32'h1234);
    chk_eq("t1_stall",    32'(stall),        32'd0);
    chk_eq("t1_ready_fl", 32'(ext_in_ready), 32'd0);
    next_cycle();
    in_sig = 1'b0;
    sample();
    chk_eq("t1_ready_back", 32'(ext_in_ready), 32'd1);

    // Load from empty buffer stalls until a word arrives
    next_cycle();
    in_sig = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk_eq("t2_stall_empty", 32'(stall),   32'd1);
      chk_eq("t2_rd_empty",    32'(rd_data), 32'd0);
      next_cycle();
    end
    ext_in_data = 16'hBEEF; ext_in_valid = 1'b1;
    sample();
    chk_eq("t2_stall_cap", 32'(stall), 32'd1);
    next_cycle();
    ext_in_valid = 1'b0;
    sample();
    chk_eq("t2_rd",    32'(rd_data), 32'hBEEF);
    chk_eq("t2_stall", 32'(stall),   32'd0);
    next_cycle();
    in_sig = 1'b0;

    // Held-full input buffer refuses further words
    ext_in_data = 16'hAAAA; ext_in_valid = 1'b1;
    next_cycle();
    ext_in_data = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk_eq("t5_ready_full", 32'(ext_in_ready), 32'd0);
      next_cycle();
    end
    ext_in_valid = 1'b0; in_sig = 1'b1;
    sample();
    chk_eq("t5_rd_first", 32'(rd_data), 32'hAAAA);
    next_cycle();
    in_sig = 1'b0;

    // Output FIFO fills, stalls, then drains in order
    ext_out_ready = 1'b0;
    out_sig = 1'b1; wr_data = 16'h0001; exp_q.push_back(16'h0001);
    sample();
    chk_eq("t3_stall_w1", 32'(stall), 32'd0);
    next_cycle();
    wr_data = 16'h0002; exp_q.push_back(16'h0002);
    sample();
    chk_eq("t3_stall_w2", 32'(stall), 32'd0);
    next_cycle();
    wr_data = 16'h0003; exp_q.push_back(16'h0003);
    sample();
    chk_eq("t3_stall_w3",  32'(stall),         32'd1);
    chk_eq("t3_head",      32'(ext_out_data),  32'h0001);
    chk_eq("t3_valid",     32'(ext_out_valid), 32'd1);
    next_cycle();
    ext_out_ready = 1'b1;
    sample();
    chk_eq("t3_stall_pop_same", 32'(stall), 32'd1);
    next_cycle();
    sample();
    chk_eq("t3_stall_done", 32'(stall), 32'd0);
    next_cycle();
    out_sig = 1'b0;
    next_cycle();
    sample();
    chk_eq("t3_empty", 32'(ext_out_valid), 32'd0);
    chk_eq("t3_q_drained", 32'(exp_q.size()), 32'd0);

    // Streaming stores with a ready consumer, pointers wrap several times
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      out_sig = 1'b1; wr_data = W'(16'h10 + k); exp_q.push_back(W'(16'h10 + k));
      sample();
      chk_eq("t4_stall", 32'(stall), 32'd0);
      next_cycle();
    end
    out_sig = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    chk_eq("t4_empty",     32'(ext_out_valid), 32'd0);
    chk_eq("t4_q_drained", 32'(exp_q.size()),  32'd0);

    // Asynchronous reset with queued words and a full input buffer
    next_cycle();
    ext_out_ready = 1'b0;
    out_sig = 1'b1; wr_data = 16'h0077;
    ext_in_data = 16'h4242; ext_in_valid = 1'b1;
    next_cycle();
    wr_data = 16'h0088; ext_in_valid = 1'b0;
    next_cycle();
    out_sig = 1'b0; in_sig = 1'b1;
    sample();
    chk_eq("t6_pre_valid", 32'(ext_out_valid), 32'd1);
    chk_eq("t6_pre_rd",    32'(rd_data),       32'h4242);
    #2;
    reset = 1'b1; out_sig = 1'b1;
    #1;
    chk_eq("t6_rst_valid", 32'(ext_out_valid), 32'd0);
    chk_eq("t6_rst_ready", 32'(ext_in_ready),  32'd0);
    chk_eq("t6_rst_rd",    32'(rd_data),       32'd0);
    chk_eq("t6_rst_stall", 32'(stall),         32'd0);
    chk_eq("t6_rst_data",  32'(ext_out_data),  32'd0);
    next_cycle();
    reset = 1'b0; in_sig = 1'b0; out_sig = 1'b0;
    sample();
    chk_eq("t6_post_valid", 32'(ext_out_valid), 32'd0);
    chk_eq("t6_post_ready", 32'(ext_in_ready),  32'd1);
    next_cycle();
    in_sig = 1'b1;
    sample();
    chk_eq("t6_post_in_empty", 32'(stall), 32'd1);
    next_cycle();
    in_sig = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
